// File: rtl/serial_add_n.sv
// Bit-serial ripple-carry adder: one full-adder cell reused over WIDTH cycles, LSB first.
// Start/ready/done handshake, one operation in flight; S/Cout hold the last result.
module serial_add_n #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cin,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_c;
    logic               r_done;
    logic [WIDTH-1:0]   r_s;
    logic               r_cout;

    logic               w_sum_bit;
    logic               w_c_next;
    logic [WIDTH-1:0]   w_sum_next;

    // Single full-adder cell on the current LSBs and the registered carry.
    assign w_sum_bit  = r_a[0] ^ r_b[0] ^ r_c;
    assign w_c_next   = (r_a[0] & r_b[0]) | (r_c & (r_a[0] ^ r_b[0]));
    assign w_sum_next = (r_sum >> 1) | (WIDTH'(w_sum_bit) << (WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_c     <= 1'b0;
            r_done  <= 1'b0;
            r_s     <= '0;
            r_cout  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_c     <= cin;
                        r_sum   <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_c   <= w_c_next;
                    r_sum <= w_sum_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    // Last bit: publish the completed sum and carry together with done.
                    if (r_cnt == LAST) begin
                        r_s     <= w_sum_next;
                        r_cout  <= w_c_next;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready = (r_state == ST_IDLE);
    assign done  = r_done;
    assign S     = r_s;
    assign Cout  = r_cout;

endmodule

// File: tb/tb_serial_add_n.sv
// Directed bench for serial_add_n: WIDTH=3 vector table, subtractor loopback,
// busy/stability and reset corner cases, plus an exhaustive WIDTH=1 instance.
module tb_serial_add_n;

    logic       clk = 1'b0;
    logic       rst;
    logic       start3, cin3, ready3, done3, Cout3;
    logic [2:0] A3, B3, S3;
    logic       start1, cin1, ready1, done1, Cout1;
    logic [0:0] A1, B1, S1;

    int total = 0;
    int bad   = 0;
    logic [2:0] prev_s3;
    logic [0:0] prev_s1;

    always #5 clk = ~clk;

    serial_add_n #(.WIDTH(3)) u_w3 (
        .clk(clk), .rst(rst), .start(start3), .cin(cin3), .A(A3), .B(B3),
        .ready(ready3), .done(done3), .S(S3), .Cout(Cout3)
    );

    serial_add_n #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .start(start1), .cin(cin1), .A(A1), .B(B1),
        .ready(ready1), .done(done1), .S(S1), .Cout(Cout1)
    );

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        logic       ci;
        logic [2:0] s;
        logic       co;
    } vec_t;

    vec_t vt[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Runs one WIDTH=3 operation; hold=1 keeps start high and drives 111/111 while busy.
    task automatic op3(input logic [2:0] a, input logic [2:0] b, input logic ci, input bit hold,
                       output logic [2:0] s, output logic co);
        int n;
        check("w3_ready_idle", 32'(ready3), 1);
        A3 = a; B3 = b; cin3 = ci; start3 = 1'b1;
        tick();
        check("w3_ready_e0", 32'(ready3), 0);
        start3 = hold;
        A3   = hold ? 3'b111 : ~a;
        B3   = hold ? 3'b111 : ~b;
        cin3 = ~ci;
        n = 0;
        while (done3 !== 1'b1 && n < 8) begin
            check("w3_s_hold", 32'(S3), 32'(prev_s3));
            check("w3_busy", 32'(ready3), 0);
            tick();
            n++;
        end
        check("w3_latency", 32'(n), 3);
        check("w3_ready_done", 32'(ready3), 0);
        s = S3; co = Cout3; prev_s3 = S3;
        tick();
        check("w3_done_pulse", 32'(done3), 0);
        check("w3_ready_back", 32'(ready3), 1);
        check("w3_s_kept", 32'(S3), 32'(s));
        start3 = 1'b0;
        if (hold) begin
            tick();
            check("w3_no_requeue", 32'(done3), 0);
            check("w3_no_requeue_rdy", 32'(ready3), 1);
        end
    endtask

    task automatic op1(input logic a, input logic b, input logic ci,
                       output logic s, output logic co);
        int n;
        check("w1_ready_idle", 32'(ready1), 1);
        A1 = a; B1 = b; cin1 = ci; start1 = 1'b1;
        tick();
        start1 = 1'b0; A1 = ~a; B1 = ~b; cin1 = ~ci;
        n = 0;
        while (done1 !== 1'b1 && n < 6) begin
            check("w1_s_hold", 32'(S1), 32'(prev_s1));
            tick();
            n++;
        end
        check("w1_latency", 32'(n), 1);
        s = S1[0]; co = Cout1; prev_s1 = S1;
        tick();
        check("w1_done_pulse", 32'(done1), 0);
        check("w1_ready_back", 32'(ready1), 1);
    endtask

    initial begin
        logic [2:0] s3, d;
        logic       c3, s1, c1, bo;
        logic [1:0] sum1;

        vt[0] = '{a: 3'b011, b: 3'b010, ci: 1'b0, s: 3'b101, co: 1'b0};
        vt[1] = '{a: 3'b111, b: 3'b001, ci: 1'b0, s: 3'b000, co: 1'b1};
        vt[2] = '{a: 3'b111, b: 3'b111, ci: 1'b1, s: 3'b111, co: 1'b1};
        vt[3] = '{a: 3'b000, b: 3'b000, ci: 1'b0, s: 3'b000, co: 1'b0};
        vt[4] = '{a: 3'b000, b: 3'b000, ci: 1'b1, s: 3'b001, co: 1'b0};
        vt[5] = '{a: 3'b101, b: 3'b011, ci: 1'b0, s: 3'b000, co: 1'b1};
        vt[6] = '{a: 3'b100, b: 3'b010, ci: 1'b1, s: 3'b111, co: 1'b0};
        vt[7] = '{a: 3'b110, b: 3'b101, ci: 1'b0, s: 3'b011, co: 1'b1};

        rst = 1'b1;
        start3 = 1'b0; cin3 = 1'b0; A3 = '0; B3 = '0;
        start1 = 1'b0; cin1 = 1'b0; A1 = '0; B1 = '0;
        prev_s3 = '0; prev_s1 = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_ready3", 32'(ready3), 1);
        check("rst_done3", 32'(done3), 0);
        check("rst_s3", 32'(S3), 0);
        check("rst_cout3", 32'(Cout3), 0);
        check("rst_ready1", 32'(ready1), 1);
        check("rst_s1", 32'(S1), 0);

        // Table of hand-computed WIDTH=3 sums.
        for (int i = 0; i < 8; i++) begin
            op3(vt[i].a, vt[i].b, vt[i].ci, 1'b0, s3, c3);
            check($sformatf("vec%0d_s", i), 32'(s3), 32'(vt[i].s));
            check($sformatf("vec%0d_cout", i), 32'(c3), 32'(vt[i].co));
        end

        // Subtractor loopback: (A-B) mod 8 + B returns A, carry equals the borrow.
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                d  = 3'(a - b);
                bo = (a < b);
                op3(d, 3'(b), 1'b0, 1'b0, s3, c3);
                check($sformatf("loop_%0d_%0d_s", a, b), 32'(s3), 32'(a));
                check($sformatf("loop_%0d_%0d_cout", a, b), 32'(c3), 32'(bo));
            end
        end

        // Busy rejection: start held and operands changed during RUN.
        op3(3'b011, 3'b010, 1'b0, 1'b0, s3, c3);
        check("busy_pre_s", 32'(s3), 5);
        op3(3'b001, 3'b001, 1'b0, 1'b1, s3, c3);
        check("busy_s", 32'(s3), 2);
        check("busy_cout", 32'(c3), 0);

        // Reset at E2 aborts the operation.
        A3 = 3'b110; B3 = 3'b011; cin3 = 1'b0; start3 = 1'b1;
        tick();
        start3 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_done", 32'(done3), 0);
        check("abort_s", 32'(S3), 0);
        check("abort_cout", 32'(Cout3), 0);
        check("abort_ready", 32'(ready3), 1);
        prev_s3 = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("abort_no_done", 32'(done3), 0);
        end
        op3(3'b001, 3'b001, 1'b0, 1'b0, s3, c3);
        check("after_abort_s", 32'(s3), 2);

        // rst and start together: start ignored.
        A3 = 3'b001; B3 = 3'b001; start3 = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; start3 = 1'b0;
        check("rst_start_ready", 32'(ready3), 1);
        check("rst_start_s", 32'(S3), 0);
        prev_s3 = '0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rst_start_no_done", 32'(done3), 0);
            check("rst_start_idle", 32'(ready3), 1);
        end

        // WIDTH=1: all eight input combinations.
        prev_s1 = S1;
        for (int i = 0; i < 8; i++) begin
            sum1 = 2'(i[2]) + 2'(i[1]) + 2'(i[0]);
            op1(i[2], i[1], i[0], s1, c1);
            check($sformatf("w1_%0d_s", i), 32'(s1), 32'(sum1[0]));
            check($sformatf("w1_%0d_cout", i), 32'(c1), 32'(sum1[1]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_add_n.md
Name: serial_add_n

Overview:
- Bit-serial ripple-carry adder: the addition counterpart of the team's combinational 3-bit borrow-chain subtractor.
- Reuses one full-adder cell over WIDTH cycles, LSB first, with a registered carry.
- Used in area-constrained datapaths and as the loopback checker for subtractor results: (A-B)+B must return A.
- Start/ready/done handshake; one operation in flight.

Parameters:
- WIDTH, 3, operand and sum width in bits. Legal range 1..32.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin an addition; accepted only when ready=1.
- cin  input  1  carry-in, sampled with A and B on acceptance.
- A  input  WIDTH  addend, sampled on acceptance.
- B  input  WIDTH  addend, sampled on acceptance.
- ready  output  1  high only in IDLE.
- done  output  1  single-cycle pulse; S and Cout are valid from this cycle.
- S  output  WIDTH  sum (A+B+cin) mod 2^WIDTH, registered.
- Cout  output  1  carry out of the MSB, registered.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE, done=0, S=0, Cout=0, ready=1, internal carry, shift registers and bit counter cleared.
  - rst has priority over start in the same cycle.
- States: IDLE, RUN, DONE. ready = (state==IDLE), decoded from state with no extra latency.
- IDLE:
  - On edge E0 with start=1: capture A, B into operand shift registers and cin into the carry flop; counter=0; go to RUN.
  - With start=0: stay in IDLE.
- RUN, edges E1..E_WIDTH, one bit per edge:
  - sum_bit = a0 ^ b0 ^ c; c_next = a0&b0 | c&(a0^b0).
  - Shift operand registers right by 1; shift sum_bit into the MSB of the internal sum register; counter++.
  - At the edge where counter reaches WIDTH-1 -> WIDTH: load S from the completed sum register and Cout from c_next; set done=1; go to DONE.
- DONE:
  - done=1 for exactly one cycle (the cycle after E_WIDTH).
  - At E_WIDTH+1: done=0, go to IDLE.
- Latency and throughput:
  - Start accepted at E0 -> done high in the cycle after E_WIDTH.
  - Next start can be accepted no earlier than E_WIDTH+2.
  - Throughput is 1 operation per WIDTH+2 cycles.
- Output stability:
  - S and Cout change only at the done-load edge or on reset.
  - They hold the previous result throughout IDLE and RUN; a new operation never disturbs them before its own done.
- start while ready=0 (RUN/DONE): ignored, not queued.
- A, B, cin changing after acceptance: no effect on the operation in flight.
- Reset mid-RUN or in DONE: operation aborted, no done pulse, outputs take reset values next cycle.
- WIDTH=1: RUN lasts one edge; done is high in the cycle after E1.
- Arithmetic:
  - {Cout,S} == A + B + cin exactly, WIDTH+1 bits, no saturation.
  - Wrap-around is reported only through Cout.

Test Plan:
1. Basic add, WIDTH=3: after reset, A=011, B=010, cin=0, start pulsed at E0 -> ready=0 at E0..E3; done=1 only in the cycle after E3; S=101, Cout=0; ready=1 after E4.
2. Overflow and carry-in: A=111, B=001, cin=0 -> S=000, Cout=1. Then A=111, B=111, cin=1 -> S=111, Cout=1.
3. Subtractor loopback: drive the 3-bit subtractor with A=101, B=110 -> difference 111, borrow 1. Feed 111+110, cin=0, to this block -> S=101 (original A), Cout=1. Repeat for all 64 A/B pairs: S must equal the original A.
4. Busy rejection and stability:
   - Complete 011+010 (S=101).
   - Start 001+001; hold start=1 and change A/B to 111/111 during RUN.
   - Required: exactly one done; S=010; S reads 101 until that done.
5. Reset mid-operation:
   - Start 110+011; assert rst at E2.
   - Required: no done pulse; S=000, Cout=0, ready=1 after E2.
   - Next start 001+001 gives S=010.
   - Also assert rst and start together: start is ignored.
6. WIDTH=1 instance, all 8 combinations of A, B, cin -> {Cout,S} = A+B+cin; done is high in the cycle after E1.
